dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_BITS, default 10, byte-address width; memory depth is 2**ADDR_BITS bytes.
REQ-002 Parameter READ_LAT, default 1, legal range 1..4, in cycles from read acceptance to rsp_valid.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  encoding: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-010 req_addr  input  ADDR_BITS  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_rdata  output  32  load result, already extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  access was misaligned or illegal.

Function
REQ-016 Storage SHALL be four byte lanes of 2**(ADDR_BITS-2) entries each, indexed by addr[ADDR_BITS-1:2], with the lane selected by addr[1:0].
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-018 Acceptance occurs when req_valid and req_ready are both high on a rising edge.
REQ-019 req_ready SHALL be high only in IDLE, which allows one outstanding request.
REQ-020 A misaligned request SHALL flag an error: half with addr[0]=1, word with addr[1:0]!=0, or any request with size 11.
REQ-021 On an error, the block SHALL NOT write memory, SHALL set rsp_err=1 and rsp_rdata=0, and SHALL transition IDLE->RESP.
REQ-022 An aligned store SHALL write only the addressed lanes at the acceptance edge, then transition IDLE->RESP.
REQ-023 Store lane rule: a byte store writes wdata[7:0] into lane addr[1:0]. A half store writes wdata[15:0] into lanes addr[1]*2 and addr[1]*2+1. A word store writes all four lanes.
REQ-024 An aligned load SHALL capture the lane word at the acceptance edge, then shift and extend it per size, offset and req_unsigned.
REQ-025 Load transition: READ_LAT=1 goes IDLE->RESP. READ_LAT>1 goes IDLE->WAIT, with a counter loaded to READ_LAT-1. WAIT decrements the counter each cycle and goes to RESP when it reaches 0.
REQ-026 rsp_valid SHALL rise exactly READ_LAT cycles after load acceptance, and exactly 1 cycle after store or error acceptance.
REQ-027 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready is high, then return to IDLE on that edge.
REQ-028 Back-to-back operation: a new request is accepted no earlier than the cycle after response handoff, which gives at most one transaction per 2 cycles when READ_LAT=1.
REQ-029 A load that follows a store to the same address SHALL return the stored data, because of strict ordering.
REQ-030 req_ready SHALL be 0 in WAIT and RESP; request inputs in those states SHALL be ignored.

Reset
REQ-031 While rst is high: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, and the latency counter is 0.
REQ-032 Reset SHALL NOT clear memory contents; simulation initial contents are all zero.
REQ-033 Reset in WAIT or RESP SHALL discard the pending response. A store committed at its acceptance edge SHALL remain written.

Verification
REQ-034 Word store 0xDEADBEEF at 0x010, then a byte load (signed) at 0x013 -> rsp_rdata=0xFFFFFFDE, rsp_err=0.
REQ-035 Half store 0x8001 at 0x022, then a half load at 0x022 -> unsigned gives 0x00008001 and signed gives 0xFFFF8001; the other lanes of word 0x020 are unchanged.
REQ-036 Word load at 0x005, and half store at 0x003 -> rsp_err=1, rsp_rdata=0, and memory at 0x000-0x007 is unchanged.
REQ-037 READ_LAT=3, load accepted at edge N -> rsp_valid first high after edge N+3; with rsp_ready held low for 5 cycles, the data stays stable and req_ready stays 0.
REQ-038 Assert rst in WAIT -> rsp_valid=0 and req_ready=1 immediately; a prior store remains readable afterwards.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory controller with valid/ready request and response channels,
// one outstanding transaction, lane-based stores and sign/zero-extended loads.
module dmem_ctrl #(
   parameter int ADDR_BITS = 10,
   parameter int READ_LAT  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [1:0]           req_size,
   input  logic                 req_unsigned,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_rdata,
   output logic                 rsp_err
);

   localparam int         IDX_BITS = ADDR_BITS - 2;
   localparam int         WORDS    = 2 ** IDX_BITS;
   localparam logic [1:0] LAT_CNT  = 2'(READ_LAT - 1);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              state, state_nx;
   logic [1:0]          cnt, cnt_nx;
   logic                accept;
   logic                misaligned;
   logic [IDX_BITS-1:0] idx;
   logic [1:0]          off;
   logic [3:0]          wmask;
   logic [31:0]         wbytes;
   logic [31:0]         load_ext;
   logic [31:0]         shifted;

   logic [7:0]          mem [4][WORDS];

   logic [31:0]         rd_word;
   logic [1:0]          ld_off;
   logic [1:0]          ld_size;
   logic                ld_uns;
   logic                ld_load;
   logic                err_q;

   assign accept = req_valid && (state == S_IDLE);
   assign idx    = req_addr[ADDR_BITS-1:2];
   assign off    = req_addr[1:0];

   always_comb begin
      unique case (req_size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = off[0];
         SZ_WORD: misaligned = (off != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   // Store data is replicated across lanes so the mask alone picks the destination.
   always_comb begin
      wmask  = 4'b0000;
      wbytes = req_wdata;
      unique case (req_size)
         SZ_BYTE: begin
            wmask  = 4'b0001 << off;
            wbytes = {4{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            wmask  = off[1] ? 4'b1100 : 4'b0011;
            wbytes = {2{req_wdata[15:0]}};
         end
         SZ_WORD: wmask = 4'b1111;
         default: wmask = 4'b0000;
      endcase
   end

   // NOTE: the storage array has no reset; clearing it would need a port per word
   // and reset must leave committed stores intact anyway.
   always_ff @(posedge clk) begin
      if (accept && req_we && !misaligned) begin
         for (int l = 0; l < 4; l++) begin
            if (wmask[l]) mem[l][idx] <= wbytes[8*l +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_word <= '0;
         ld_off  <= '0;
         ld_size <= '0;
         ld_uns  <= 1'b0;
         ld_load <= 1'b0;
         err_q   <= 1'b0;
      end else if (accept) begin
         err_q   <= misaligned;
         ld_load <= !req_we && !misaligned;
         ld_off  <= off;
         ld_size <= req_size;
         ld_uns  <= req_unsigned;
         if (!req_we && !misaligned)
            rd_word <= {mem[3][idx], mem[2][idx], mem[1][idx], mem[0][idx]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // NOTE: defaults first so no path through the case leaves a variable unassigned
   // (which would infer a latch).
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               if (req_we || misaligned || READ_LAT <= 1) begin
                  state_nx = S_RESP;
               end else begin
                  state_nx = S_WAIT;
                  cnt_nx   = LAT_CNT;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 2'd0) state_nx = S_RESP;
            else             cnt_nx   = cnt - 2'd1;
         end
         S_RESP: begin
            if (rsp_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      shifted  = rd_word >> {ld_off, 3'b000};
      load_ext = rd_word;
      unique case (ld_size)
         SZ_BYTE: load_ext = ld_uns ? {24'd0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_ext = ld_uns ? {16'd0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
         default: load_ext = rd_word;
      endcase
   end

   always_comb begin
      req_ready = (state == S_IDLE);
      rsp_valid = (state == S_RESP);
      rsp_err   = rsp_valid && err_q;
      rsp_rdata = (rsp_valid && ld_load) ? load_ext : 32'd0;
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance at READ_LAT=1 and one at READ_LAT=3,
// expected responses queued at issue and compared when each response appears.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  rsp_ready;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_err;
   logic [31:0] rsp_rdata [2];

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   dmem_ctrl #(.ADDR_BITS(10), .READ_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   dmem_ctrl #(.ADDR_BITS(10), .READ_LAT(3)) u_lat3 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request on instance s, then collect and hand off its response.
   task automatic do_req(input int s, input logic we, input logic [1:0] size,
                         input logic uns, input logic [9:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int hold, input string tag);
      exp_t e;
      int   n;
      logic [31:0] held;
      sb.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat});
      @(negedge clk);
      n = 0;
      while (!req_ready[s] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " ready"}, 32'(req_ready[s]), 32'd1);
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      req_valid[s] = 1'b1;
      @(posedge clk);
      #1 req_valid[s] = 1'b0;
      @(negedge clk);
      check({tag, " busy"}, 32'(req_ready[s]), 32'd0);
      n = 0;
      while (!rsp_valid[s] && n < 20) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      check({tag, " lat"}, 32'(n), 32'(e.lat));
      check({tag, " rdata"}, rsp_rdata[s], e.rdata);
      check({tag, " err"}, 32'(rsp_err[s]), 32'(e.err));
      held = rsp_rdata[s];
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, " hold valid"}, 32'(rsp_valid[s]), 32'd1);
         check({tag, " hold rdata"}, rsp_rdata[s], held);
         check({tag, " hold ready"}, 32'(req_ready[s]), 32'd0);
      end
      rsp_ready[s] = 1'b1;
      @(posedge clk);
      #1 rsp_ready[s] = 1'b0;
      @(negedge clk);
      check({tag, " handoff"}, {30'd0, rsp_valid[s], req_ready[s]}, 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0; rsp_ready = '0;
      req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         check("reset ready", 32'(req_ready[s]), 32'd1);
         check("reset valid", 32'(rsp_valid[s]), 32'd0);
         check("reset err",   32'(rsp_err[s]),   32'd0);
         check("reset rdata", rsp_rdata[s],      32'd0);
      end
      rst = 1'b0;

      // READ_LAT=1: store then extended loads of the same word
      do_req(0, 1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 32'h0,        0, 0, 0, "st_w 010");
      do_req(0, 0, 2'b00, 0, 10'h013, 32'h0,        32'hFFFFFFDE, 0, 0, 0, "ld_b 013 s");
      do_req(0, 0, 2'b00, 1, 10'h013, 32'h0,        32'h000000DE, 0, 0, 0, "ld_b 013 u");
      do_req(0, 0, 2'b00, 0, 10'h010, 32'h0,        32'hFFFFFFEF, 0, 0, 0, "ld_b 010 s");

      do_req(0, 1, 2'b10, 0, 10'h020, 32'h12345678, 32'h0,        0, 0, 0, "st_w 020");
      do_req(0, 1, 2'b01, 0, 10'h022, 32'h00008001, 32'h0,        0, 0, 0, "st_h 022");
      do_req(0, 0, 2'b01, 1, 10'h022, 32'h0,        32'h00008001, 0, 0, 0, "ld_h 022 u");
      do_req(0, 0, 2'b01, 0, 10'h022, 32'h0,        32'hFFFF8001, 0, 0, 0, "ld_h 022 s");
      do_req(0, 0, 2'b10, 0, 10'h020, 32'h0,        32'h80015678, 0, 0, 0, "ld_w 020");

      // Misaligned and illegal accesses must not touch memory
      do_req(0, 1, 2'b10, 0, 10'h000, 32'hA5A5A5A5, 32'h0,        0, 0, 0, "st_w 000");
      do_req(0, 1, 2'b10, 0, 10'h004, 32'h5A5A5A5A, 32'h0,        0, 0, 0, "st_w 004");
      do_req(0, 0, 2'b10, 0, 10'h005, 32'h0,        32'h0,        1, 0, 0, "ld_w 005 err");
      do_req(0, 1, 2'b01, 0, 10'h003, 32'hFFFFFFFF, 32'h0,        1, 0, 0, "st_h 003 err");
      do_req(0, 1, 2'b11, 0, 10'h000, 32'hFFFFFFFF, 32'h0,        1, 0, 0, "st_sz3 err");
      do_req(0, 0, 2'b10, 0, 10'h000, 32'h0,        32'hA5A5A5A5, 0, 0, 0, "ld_w 000");
      do_req(0, 0, 2'b10, 0, 10'h004, 32'h0,        32'h5A5A5A5A, 0, 0, 0, "ld_w 004");
      do_req(0, 1, 2'b00, 0, 10'h001, 32'hFFFFFF77, 32'h0,        0, 0, 0, "st_b 001");
      do_req(0, 0, 2'b10, 0, 10'h000, 32'h0,        32'hA5A577A5, 0, 0, 0, "ld_w 000 b");

      // READ_LAT=3: latency, stall with rsp_ready low, error path stays one cycle
      do_req(1, 1, 2'b10, 0, 10'h030, 32'hCAFEF00D, 32'h0,        0, 0, 0, "l3 st_w 030");
      do_req(1, 0, 2'b01, 0, 10'h032, 32'h0,        32'hFFFFCAFE, 0, 3, 5, "l3 ld_h 032");
      do_req(1, 0, 2'b00, 1, 10'h031, 32'h0,        32'h000000F0, 0, 3, 0, "l3 ld_b 031");
      do_req(1, 0, 2'b10, 0, 10'h032, 32'h0,        32'h0,        1, 0, 0, "l3 ld_w err");

      // Reset while a load waits; a store offered during WAIT is ignored
      do_req(1, 1, 2'b10, 0, 10'h040, 32'h11223344, 32'h0,        0, 0, 0, "l3 st_w 040");
      @(negedge clk);
      req_we = 1'b0; req_size = 2'b10; req_addr = 10'h040;
      req_valid[1] = 1'b1;
      @(posedge clk);
      #1;
      req_we = 1'b1; req_wdata = 32'hFFFFFFFF;
      @(negedge clk);
      check("wait ready", 32'(req_ready[1]), 32'd0);
      check("wait valid", 32'(rsp_valid[1]), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst wait valid", 32'(rsp_valid[1]), 32'd0);
      check("rst wait ready", 32'(req_ready[1]), 32'd1);
      req_valid[1] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      do_req(1, 0, 2'b10, 0, 10'h040, 32'h0,        32'h11223344, 0, 3, 0, "l3 ld_w 040");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
